// File: rtl/sys_bus_arb_if.sv
// sys_bus_arb_if: master-side and slave-side signal bundle of the shared system bus
interface sys_bus_arb_if #(
  parameter int N_MASTERS = 3,
  parameter int AW = 16,
  parameter int DW = 8
);
  logic [N_MASTERS-1:0]    m_req;
  logic [N_MASTERS*AW-1:0] m_a;
  logic [N_MASTERS*DW-1:0] m_dout;
  logic [N_MASTERS-1:0]    m_rd;
  logic [N_MASTERS-1:0]    m_wr;
  logic [N_MASTERS-1:0]    m_gnt;
  logic [DW-1:0]           m_din;
  logic [N_MASTERS-1:0]    m_rvalid;
  logic [AW-1:0]           s_a;
  logic [DW-1:0]           s_dout;
  logic                    s_rd;
  logic                    s_wr;
  logic [DW-1:0]           s_din;
  logic [2:0]              owner;
  logic                    busy;
  logic                    timeout;
  modport master (
    output m_req, m_a, m_dout, m_rd, m_wr, s_din,
    input  m_gnt, m_din, m_rvalid, s_a, s_dout, s_rd, s_wr, owner, busy, timeout
  );
  modport slave (
    input  m_req, m_a, m_dout, m_rd, m_wr, s_din,
    output m_gnt, m_din, m_rvalid, s_a, s_dout, s_rd, s_wr, owner, busy, timeout
  );
endinterface

// File: rtl/sys_bus_arb.sv
// sys_bus_arb: N-master bus arbiter/mux with hold pre-emption; BUS_RR_EN selects round-robin
module sys_bus_arb #(
  parameter int N_MASTERS = 3,
  parameter int AW = 16,
  parameter int DW = 8,
  parameter int MAX_HOLD = 160
) (
  input logic clk,
  input logic rst,
  sys_bus_arb_if.slave bus
);
  localparam int CW = $clog2(MAX_HOLD + 2);
  localparam logic [N_MASTERS-1:0] ONE = {{(N_MASTERS-1){1'b0}}, 1'b1};
  typedef enum logic {IDLE, OWN} state_t;
  state_t state, state_n;
  logic [N_MASTERS-1:0] gnt, gnt_n, elig, rvalid;
  logic [2:0] owner, owner_n, win;
  logic [CW-1:0] cnt, cnt_n;
  logic tmo, tmo_n, take, hold_hit, own_req;
  logic [DW-1:0] din, sdout;
  logic [AW-1:0] sa;
  logic srd, swr;
  assign elig = bus.m_req & ~gnt;
  assign hold_hit = (MAX_HOLD != 0) && (32'(cnt) + 32'd1 >= 32'(MAX_HOLD));
`ifdef BUS_RR_EN
  logic [2:0] rr_ptr;
  // round-robin pick: lowest requester above the last owner, else lowest at or below it
  always_comb begin
    win = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) if (elig[i] && 3'(i) <= rr_ptr) win = 3'(i);
    for (int i = N_MASTERS - 1; i >= 0; i--) if (elig[i] && 3'(i) > rr_ptr) win = 3'(i);
  end
  // pointer tracks the most recent grant
  always_ff @(posedge clk or posedge rst)
    if (rst) rr_ptr <= 3'(N_MASTERS - 1);
    else if (take) rr_ptr <= win;
`else
  // fixed priority pick: lowest eligible index
  always_comb begin
    win = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) if (elig[i]) win = 3'(i);
  end
`endif
  // route the owner's request and strobes onto the shared bus; nothing drives it while idle
  always_comb begin
    sa = '0;
    sdout = '0;
    srd = 1'b0;
    swr = 1'b0;
    own_req = 1'b0;
    for (int i = 0; i < N_MASTERS; i++)
      if (state == OWN && !rst && owner == 3'(i)) begin
        sa = bus.m_a[i*AW +: AW];
        sdout = bus.m_dout[i*DW +: DW];
        srd = bus.m_rd[i];
        swr = bus.m_wr[i];
        own_req = bus.m_req[i];
      end
  end
  // release beats pre-emption, so a same-cycle drop never raises timeout
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    owner_n = owner;
    cnt_n = cnt;
    tmo_n = 1'b0;
    take = 1'b0;
    if (state == IDLE || !own_req) begin
      if (|elig) take = 1'b1;
      else if (state == OWN) begin
        state_n = IDLE;
        gnt_n = '0;
      end
    end else if (hold_hit && |elig) begin
      take = 1'b1;
      tmo_n = 1'b1;
    end else if (32'(cnt) < 32'(MAX_HOLD)) cnt_n = cnt + 1'b1;
    if (take) begin
      state_n = OWN;
      gnt_n = ONE << win;
      owner_n = win;
      cnt_n = '0;
    end
  end
  // arbitration state register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      owner <= '0;
      cnt <= '0;
      tmo <= 1'b0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      owner <= owner_n;
      cnt <= cnt_n;
      tmo <= tmo_n;
    end
  // capture read data and flag it to the master that issued the read
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      din <= '0;
      rvalid <= '0;
    end else begin
      rvalid <= srd ? ONE << owner : '0;
      din <= srd ? bus.s_din : din;
    end
  assign bus.m_gnt = gnt;
  assign bus.m_din = din;
  assign bus.m_rvalid = rvalid;
  assign bus.s_a = sa;
  assign bus.s_dout = sdout;
  assign bus.s_rd = srd;
  assign bus.s_wr = swr;
  assign bus.owner = owner;
  assign bus.busy = state == OWN;
  assign bus.timeout = tmo;
endmodule
